// File: rtl/amt_recovery_ctrl_pkg.sv
// rtl/amt_recovery_ctrl_pkg.sv - shared constants, state enum and RMT packet type
package amt_recovery_ctrl_pkg;

  localparam int SIZE_RMT          = 32;
  localparam int SIZE_RMT_LOG      = 5;
  localparam int SIZE_PHYSICAL_LOG = 7;
  localparam int COMMIT_WIDTH      = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DRAIN   = 2'd1,
    WALK    = 2'd2,
    REBUILD = 2'd3
  } state_t;

  typedef struct packed {
    logic [SIZE_RMT_LOG-1:0]      logical;
    logic [SIZE_PHYSICAL_LOG-1:0] physical;
  } rmt_packet_t;

endpackage

// File: rtl/amt_recovery_ctrl_if.sv
// rtl/amt_recovery_ctrl_if.sv - recovery request, AMT read and RMT write signals
interface amt_recovery_ctrl_if;
  import amt_recovery_ctrl_pkg::*;

  logic                                            recover_req;
  logic [COMMIT_WIDTH-1:0][SIZE_PHYSICAL_LOG-1:0]  amt_data;
  logic                                            commit_block;
  logic                                            stall_front_end;
  logic                                            amt_recover_mode;
  logic [SIZE_RMT_LOG-1:0]                         recover_cnt;
  logic [COMMIT_WIDTH-1:0]                         rmt_we;
  rmt_packet_t [COMMIT_WIDTH-1:0]                  rmt_packet;
  logic                                            free_list_rebuild;
  logic                                            recovery_done;

  modport master (
    input  recover_req, amt_data,
    output commit_block, stall_front_end, amt_recover_mode, recover_cnt,
           rmt_we, rmt_packet, free_list_rebuild, recovery_done
  );

  modport slave (
    output recover_req, amt_data,
    input  commit_block, stall_front_end, amt_recover_mode, recover_cnt,
           rmt_we, rmt_packet, free_list_rebuild, recovery_done
  );

endinterface

// File: rtl/amt_recovery_ctrl_packer.sv
// rtl/amt_recovery_ctrl_packer.sv - builds the four RMT write packets for the current AMT group
module amt_recover_packer
  import amt_recovery_ctrl_pkg::*;
(
  input  logic                                           walk,
  input  logic [SIZE_RMT_LOG-1:0]                        recover_cnt,
  input  logic [COMMIT_WIDTH-1:0][SIZE_PHYSICAL_LOG-1:0] amt_data,
  output rmt_packet_t [COMMIT_WIDTH-1:0]                 rmt_packet
);

  // The AMT read is combinational, so packets follow amt_data in the same cycle.
  always_comb begin
    rmt_packet = '0;
    if (walk) begin
      for (int k = 0; k < COMMIT_WIDTH; k++) begin
        rmt_packet[k].logical  = recover_cnt + SIZE_RMT_LOG'(k);
        rmt_packet[k].physical = amt_data[k];
      end
    end
  end

endmodule

// File: rtl/amt_recovery_ctrl.sv
// rtl/amt_recovery_ctrl.sv - blocks commit, drains, walks the AMT into the RMT, then rebuilds the free list
module amt_recovery_ctrl
  import amt_recovery_ctrl_pkg::*;
#(
  parameter int DRAIN_CYCLES = 1
) (
  input  logic               clk,
  input  logic               reset,
  amt_recovery_ctrl_if.master bus
);

  localparam logic [SIZE_RMT_LOG-1:0] LAST_GROUP = SIZE_RMT_LOG'(SIZE_RMT - COMMIT_WIDTH);
  localparam logic [SIZE_RMT_LOG-1:0] GROUP_STEP = SIZE_RMT_LOG'(COMMIT_WIDTH);

  state_t                  state;
  logic [2:0]              drain_cnt;
  logic [SIZE_RMT_LOG-1:0] recover_cnt;
  logic                    commit_block;
  logic                    amt_recover_mode;
  logic [COMMIT_WIDTH-1:0] rmt_we;
  logic                    free_list_rebuild;
  logic                    recovery_done;
  rmt_packet_t [COMMIT_WIDTH-1:0] rmt_packet;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state             <= IDLE;
      drain_cnt         <= '0;
      recover_cnt       <= '0;
      commit_block      <= 1'b0;
      amt_recover_mode  <= 1'b0;
      rmt_we            <= '0;
      free_list_rebuild <= 1'b0;
      recovery_done     <= 1'b0;
    end else begin
      free_list_rebuild <= 1'b0;
      recovery_done     <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.recover_req) begin
            state        <= DRAIN;
            drain_cnt    <= 3'(DRAIN_CYCLES - 1);
            commit_block <= 1'b1;
          end
        end
        DRAIN: begin
          if (drain_cnt == 3'd0) begin
            state            <= WALK;
            recover_cnt      <= '0;
            amt_recover_mode <= 1'b1;
            rmt_we           <= '1;
          end else begin
            drain_cnt <= drain_cnt - 3'd1;
          end
        end
        WALK: begin
          if (recover_cnt == LAST_GROUP) begin
            state             <= REBUILD;
            recover_cnt       <= '0;
            amt_recover_mode  <= 1'b0;
            rmt_we            <= '0;
            free_list_rebuild <= 1'b1;
            recovery_done     <= 1'b1;
          end else begin
            recover_cnt <= recover_cnt + GROUP_STEP;
          end
        end
        REBUILD: begin
          state        <= IDLE;
          commit_block <= 1'b0;
        end
        default: begin
          state            <= IDLE;
          recover_cnt      <= '0;
          commit_block     <= 1'b0;
          amt_recover_mode <= 1'b0;
          rmt_we           <= '0;
        end
      endcase
    end
  end

  amt_recover_packer u_packer (
    .walk        (amt_recover_mode),
    .recover_cnt (recover_cnt),
    .amt_data    (bus.amt_data),
    .rmt_packet  (rmt_packet)
  );

  // Commit block and front-end stall share one register: both cover every non-IDLE state.
  assign bus.commit_block      = commit_block;
  assign bus.stall_front_end   = commit_block;
  assign bus.amt_recover_mode  = amt_recover_mode;
  assign bus.recover_cnt       = recover_cnt;
  assign bus.rmt_we            = rmt_we;
  assign bus.rmt_packet        = rmt_packet;
  assign bus.free_list_rebuild = free_list_rebuild;
  assign bus.recovery_done     = recovery_done;

endmodule

// File: tb/tb_amt_recovery_ctrl.sv
// tb/tb_amt_recovery_ctrl.sv - directed timeline checks for amt_recovery_ctrl
module tb_amt_recovery_ctrl;
  import amt_recovery_ctrl_pkg::*;

  logic clk;
  logic reset;
  logic sel;
  int   checks;
  int   fails;

  amt_recovery_ctrl_if if1 ();
  amt_recovery_ctrl_if if3 ();

  amt_recovery_ctrl #(.DRAIN_CYCLES(1)) dut1 (.clk(clk), .reset(reset), .bus(if1.master));
  amt_recovery_ctrl #(.DRAIN_CYCLES(3)) dut3 (.clk(clk), .reset(reset), .bus(if3.master));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // AMT model: physical tag = logical index + 64
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      if1.amt_data[k] = 7'(64 + int'(if1.recover_cnt) + k);
    end
  end
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      if3.amt_data[k] = 7'(64 + int'(if3.recover_cnt) + k);
    end
  end

  logic        o_cb, o_stall, o_mode, o_rebuild, o_done;
  logic [4:0]  o_cnt;
  logic [3:0]  o_we;
  rmt_packet_t [3:0] o_pkt;

  always_comb begin
    if (sel) begin
      o_cb = if3.commit_block; o_stall = if3.stall_front_end; o_mode = if3.amt_recover_mode;
      o_rebuild = if3.free_list_rebuild; o_done = if3.recovery_done; o_cnt = if3.recover_cnt;
      o_we = if3.rmt_we; o_pkt = if3.rmt_packet;
    end else begin
      o_cb = if1.commit_block; o_stall = if1.stall_front_end; o_mode = if1.amt_recover_mode;
      o_rebuild = if1.free_list_rebuild; o_done = if1.recovery_done; o_cnt = if1.recover_cnt;
      o_we = if1.rmt_we; o_pkt = if1.rmt_packet;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic v);
    if (sel) if3.recover_req = v;
    else     if1.recover_req = v;
  endtask

  task automatic check_idle_outputs(input string tag);
    checks++;
    if (o_cb !== 1'b0 || o_stall !== 1'b0 || o_mode !== 1'b0 || o_rebuild !== 1'b0 ||
        o_done !== 1'b0 || o_cnt !== 5'd0 || o_we !== 4'd0 || o_pkt !== '0) begin
      fails++;
      $display("FAIL %s: cb=%0b stall=%0b mode=%0b rebuild=%0b done=%0b cnt=%0d we=%b pkt=%h, want all 0",
               tag, o_cb, o_stall, o_mode, o_rebuild, o_done, o_cnt, o_we, o_pkt);
    end
  endtask

  // Request in the current cycle (cycle 0), check every cycle through done+1.
  task automatic run_sequence(input int drain, input int dup_cycle, input string tag);
    int ws, done_c, walks, dones;
    logic exp_cb, exp_walk, exp_done;
    logic [4:0] exp_cnt;
    ws = 1 + drain;
    done_c = ws + 8;
    walks = 0;
    dones = 0;
    set_req(1'b1);
    for (int k = 1; k <= done_c + 1; k++) begin
      tick();
      set_req(k == dup_cycle);
      exp_cb   = (k <= done_c);
      exp_walk = (k >= ws) && (k < ws + 8);
      exp_cnt  = exp_walk ? 5'(4 * (k - ws)) : 5'd0;
      exp_done = (k == done_c);
      checks++;
      if (o_cb !== exp_cb || o_stall !== exp_cb) begin
        fails++;
        $display("FAIL %s cycle %0d block: cb=%0b stall=%0b want %0b", tag, k, o_cb, o_stall, exp_cb);
      end
      checks++;
      if (o_cnt !== exp_cnt || o_we !== {4{exp_walk}} || o_mode !== exp_walk) begin
        fails++;
        $display("FAIL %s cycle %0d walk: cnt=%0d we=%b mode=%0b want cnt=%0d we=%b mode=%0b",
                 tag, k, o_cnt, o_we, o_mode, exp_cnt, {4{exp_walk}}, exp_walk);
      end
      checks++;
      if (o_done !== exp_done || o_rebuild !== exp_done) begin
        fails++;
        $display("FAIL %s cycle %0d done: done=%0b rebuild=%0b want %0b", tag, k, o_done, o_rebuild, exp_done);
      end
      if (!exp_walk) begin
        checks++;
        if (o_pkt !== '0) begin
          fails++;
          $display("FAIL %s cycle %0d pkt_idle: pkt=%h want 0", tag, k, o_pkt);
        end
      end
      if (k == ws + 2) begin
        for (int j = 0; j < 4; j++) begin
          checks++;
          if (o_pkt[j].logical !== 5'(8 + j) || o_pkt[j].physical !== 7'(72 + j)) begin
            fails++;
            $display("FAIL %s pkt%0d: {%0d,%0d} want {%0d,%0d}", tag, j,
                     o_pkt[j].logical, o_pkt[j].physical, 8 + j, 72 + j);
          end
        end
      end
      if (o_we === 4'hf) walks++;
      if (o_done === 1'b1) dones++;
    end
    checks++;
    if (walks != 8 || dones != 1) begin
      fails++;
      $display("FAIL %s counts: walk_cycles=%0d done_pulses=%0d want 8 and 1", tag, walks, dones);
    end
  endtask

  task automatic test_reset();
    sel = 1'b0;
    reset = 1'b0;
    if1.recover_req = 1'b0;
    if3.recover_req = 1'b0;
    tick();
    tick();
    check_idle_outputs("reset_dut1");
    sel = 1'b1;
    #0;
    check_idle_outputs("reset_dut3");
    sel = 1'b0;
    reset = 1'b1;
    tick();
    check_idle_outputs("after_release");
  endtask

  task automatic test_basic();
    sel = 1'b0;
    run_sequence(1, -1, "basic");
  endtask

  task automatic test_duplicate();
    sel = 1'b0;
    tick();
    run_sequence(1, 5, "duplicate");
  endtask

  task automatic test_back_to_back();
    sel = 1'b0;
    tick();
    run_sequence(1, -1, "b2b_first");
    run_sequence(1, -1, "b2b_second");
  endtask

  task automatic test_drain3();
    sel = 1'b1;
    tick();
    run_sequence(3, -1, "drain3");
    sel = 1'b0;
  endtask

  task automatic test_reset_mid_walk();
    sel = 1'b0;
    tick();
    set_req(1'b1);
    for (int k = 1; k <= 5; k++) begin
      tick();
      set_req(1'b0);
    end
    checks++;
    if (o_we !== 4'hf || o_cnt !== 5'd12) begin
      fails++;
      $display("FAIL midwalk_pre: we=%b cnt=%0d want 1111 and 12", o_we, o_cnt);
    end
    #2;
    reset = 1'b0;
    #1;
    check_idle_outputs("midwalk_async");
    tick();
    reset = 1'b1;
    tick();
    check_idle_outputs("midwalk_release");
    tick();
    check_idle_outputs("midwalk_stays_idle");
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    sel    = 1'b0;
    test_reset();
    test_basic();
    test_duplicate();
    test_back_to_back();
    test_drain3();
    test_reset_mid_walk();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
